// File: rtl/pcs_rx_sync.sv
// pcs_rx_sync: 1000BASE-X PCS receive code-group synchronization.
// Consumes one 10-bit code group per GTX_CLK edge. It tracks comma
// alignment and code-group validity through the synchronization state
// machine and reports code_sync_status. Each group is forwarded one cycle
// later, together with its even/odd position label.
module pcs_rx_sync #(
    parameter int GOOD_CGS_MAX = 3
) (
    input  logic       GTX_CLK,
    input  logic       mr_main_reset,
    input  logic       signal_detect,
    input  logic [9:0] rx_code_group,
    input  logic       cg_invalid,
    output logic [9:0] rx_code_group_out,
    output logic       rx_even,
    output logic       code_sync_status
);

    // State encoding. Codes 13..15 are unused and fall back to LOSS_OF_SYNC.
    localparam logic [3:0] ST_LOSS_OF_SYNC = 4'd0;
    localparam logic [3:0] ST_COMMA_DET_1  = 4'd1;
    localparam logic [3:0] ST_COMMA_DET_2  = 4'd2;
    localparam logic [3:0] ST_COMMA_DET_3  = 4'd3;
    localparam logic [3:0] ST_ACQ_SYNC_1   = 4'd4;
    localparam logic [3:0] ST_ACQ_SYNC_2   = 4'd5;
    localparam logic [3:0] ST_SYNC_ACQ_1   = 4'd6;
    localparam logic [3:0] ST_SYNC_ACQ_2   = 4'd7;
    localparam logic [3:0] ST_SYNC_ACQ_3   = 4'd8;
    localparam logic [3:0] ST_SYNC_ACQ_4   = 4'd9;
    localparam logic [3:0] ST_SYNC_ACQ_2A  = 4'd10;
    localparam logic [3:0] ST_SYNC_ACQ_3A  = 4'd11;
    localparam logic [3:0] ST_SYNC_ACQ_4A  = 4'd12;

    // Good-group run length that steps the machine back up one level.
    localparam logic [1:0] GOOD_MAX_C = 2'(GOOD_CGS_MAX);

    // Comma: the seven-bit prefix abcdeif of K28.1/K28.5/K28.7 in either disparity.
    function automatic logic f_is_comma(input logic [9:0] cg);
        logic res;
        res = (cg[9:3] == 7'b0011111) || (cg[9:3] == 7'b1100000);
        return res;
    endfunction

    // Control code decode: K28.0..K28.7 and K23/27/29/30.7, both disparities.
    function automatic logic f_is_kcode(input logic [9:0] cg);
        logic res;
        case (cg)
            10'b0011110100, 10'b1100001011,   // K28.0
            10'b0011111001, 10'b1100000110,   // K28.1
            10'b0011110101, 10'b1100001010,   // K28.2
            10'b0011110011, 10'b1100001100,   // K28.3
            10'b0011110010, 10'b1100001101,   // K28.4
            10'b0011111010, 10'b1100000101,   // K28.5
            10'b0011110110, 10'b1100001001,   // K28.6
            10'b0011111000, 10'b1100000111,   // K28.7
            10'b1110101000, 10'b0001010111,   // K23.7
            10'b1101101000, 10'b0010010111,   // K27.7
            10'b1011101000, 10'b0100010111,   // K29.7
            10'b0111101000, 10'b1000010111:   // K30.7
                res = 1'b1;
            default:
                res = 1'b0;
        endcase
        return res;
    endfunction

    // True for every SYNC_ACQUIRED_* state.
    function automatic logic f_is_synced(input logic [3:0] st);
        logic res;
        case (st)
            ST_SYNC_ACQ_1, ST_SYNC_ACQ_2, ST_SYNC_ACQ_3, ST_SYNC_ACQ_4,
            ST_SYNC_ACQ_2A, ST_SYNC_ACQ_3A, ST_SYNC_ACQ_4A:
                res = 1'b1;
            default:
                res = 1'b0;
        endcase
        return res;
    endfunction

    // True for the three COMMA_DETECT states, where the even label is forced.
    function automatic logic f_is_comma_det(input logic [3:0] st);
        logic res;
        case (st)
            ST_COMMA_DET_1, ST_COMMA_DET_2, ST_COMMA_DET_3:
                res = 1'b1;
            default:
                res = 1'b0;
        endcase
        return res;
    endfunction

    logic [3:0] r_state;
    logic [3:0] w_state_next;
    logic [1:0] r_good_cgs;
    logic [1:0] w_good_cgs_next;
    logic [9:0] r_cg_out;
    logic       r_even;
    logic       r_sync_status;
    logic       w_even_next;
    logic       w_sync_status_next;

    logic       w_comma;
    logic       w_is_k;
    logic       w_is_d;
    logic       w_cg_bad;
    logic       w_cg_good;
    logic       w_good_run_done;

    // Qualifiers on the code group consumed at this edge. A comma is bad when
    // the previous group was already labelled even.
    always_comb begin
        w_comma         = f_is_comma(rx_code_group);
        w_is_k          = f_is_kcode(rx_code_group);
        w_is_d          = !w_comma && !w_is_k;
        w_cg_bad        = cg_invalid || (w_comma && r_even);
        w_cg_good       = !w_cg_bad;
        w_good_run_done = (r_good_cgs == GOOD_MAX_C);
    end

    // State register.
    always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            r_state <= ST_LOSS_OF_SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. Loss of signal overrides every other transition.
    always_comb begin
        w_state_next = ST_LOSS_OF_SYNC;
        if (!signal_detect) begin
            w_state_next = ST_LOSS_OF_SYNC;
        end else begin
            case (r_state)
                ST_LOSS_OF_SYNC: begin
                    if (w_comma && !cg_invalid) begin
                        w_state_next = ST_COMMA_DET_1;
                    end else begin
                        w_state_next = ST_LOSS_OF_SYNC;
                    end
                end
                ST_COMMA_DET_1: begin
                    if (w_is_d && !cg_invalid) begin
                        w_state_next = ST_ACQ_SYNC_1;
                    end else begin
                        w_state_next = ST_LOSS_OF_SYNC;
                    end
                end
                ST_COMMA_DET_2: begin
                    if (w_is_d && !cg_invalid) begin
                        w_state_next = ST_ACQ_SYNC_2;
                    end else begin
                        w_state_next = ST_LOSS_OF_SYNC;
                    end
                end
                ST_COMMA_DET_3: begin
                    if (w_is_d && !cg_invalid) begin
                        w_state_next = ST_SYNC_ACQ_1;
                    end else begin
                        w_state_next = ST_LOSS_OF_SYNC;
                    end
                end
                ST_ACQ_SYNC_1: begin
                    if (w_cg_bad) begin
                        w_state_next = ST_LOSS_OF_SYNC;
                    end else if (w_comma && !r_even && !cg_invalid) begin
                        w_state_next = ST_COMMA_DET_2;
                    end else begin
                        w_state_next = ST_ACQ_SYNC_1;
                    end
                end
                ST_ACQ_SYNC_2: begin
                    if (w_cg_bad) begin
                        w_state_next = ST_LOSS_OF_SYNC;
                    end else if (w_comma && !r_even && !cg_invalid) begin
                        w_state_next = ST_COMMA_DET_3;
                    end else begin
                        w_state_next = ST_ACQ_SYNC_2;
                    end
                end
                ST_SYNC_ACQ_1: begin
                    if (w_cg_bad) begin
                        w_state_next = ST_SYNC_ACQ_2;
                    end else begin
                        w_state_next = ST_SYNC_ACQ_1;
                    end
                end
                ST_SYNC_ACQ_2: begin
                    if (w_cg_good) begin
                        w_state_next = ST_SYNC_ACQ_2A;
                    end else begin
                        w_state_next = ST_SYNC_ACQ_3;
                    end
                end
                ST_SYNC_ACQ_3: begin
                    if (w_cg_good) begin
                        w_state_next = ST_SYNC_ACQ_3A;
                    end else begin
                        w_state_next = ST_SYNC_ACQ_4;
                    end
                end
                ST_SYNC_ACQ_4: begin
                    if (w_cg_good) begin
                        w_state_next = ST_SYNC_ACQ_4A;
                    end else begin
                        w_state_next = ST_LOSS_OF_SYNC;
                    end
                end
                ST_SYNC_ACQ_2A: begin
                    if (w_cg_bad) begin
                        w_state_next = ST_SYNC_ACQ_3;
                    end else if (w_good_run_done) begin
                        w_state_next = ST_SYNC_ACQ_1;
                    end else begin
                        w_state_next = ST_SYNC_ACQ_2A;
                    end
                end
                ST_SYNC_ACQ_3A: begin
                    if (w_cg_bad) begin
                        w_state_next = ST_SYNC_ACQ_4;
                    end else if (w_good_run_done) begin
                        w_state_next = ST_SYNC_ACQ_2;
                    end else begin
                        w_state_next = ST_SYNC_ACQ_3A;
                    end
                end
                ST_SYNC_ACQ_4A: begin
                    if (w_cg_bad) begin
                        w_state_next = ST_LOSS_OF_SYNC;
                    end else if (w_good_run_done) begin
                        w_state_next = ST_SYNC_ACQ_3;
                    end else begin
                        w_state_next = ST_SYNC_ACQ_4A;
                    end
                end
                default: begin
                    w_state_next = ST_LOSS_OF_SYNC;
                end
            endcase
        end
    end

    // Output-side next values, all derived from the state being entered.
    // The good-group counter clears on entry to SYNC_ACQUIRED_2/3/4 and
    // increments on every entry or re-entry of the matching "A" state.
    always_comb begin
        w_good_cgs_next    = 2'd0;
        w_even_next        = 1'b0;
        w_sync_status_next = 1'b0;
        case (w_state_next)
            ST_SYNC_ACQ_2A, ST_SYNC_ACQ_3A, ST_SYNC_ACQ_4A:
                w_good_cgs_next = r_good_cgs + 2'd1;
            default:
                w_good_cgs_next = 2'd0;
        endcase
        if (f_is_comma_det(w_state_next)) begin
            w_even_next = 1'b1;
        end else begin
            w_even_next = ~r_even;
        end
        w_sync_status_next = f_is_synced(w_state_next);
    end

    // Registered outputs and the good-group counter.
    always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            r_cg_out      <= 10'd0;
            r_even        <= 1'b0;
            r_sync_status <= 1'b0;
            r_good_cgs    <= 2'd0;
        end else begin
            r_cg_out      <= rx_code_group;
            r_even        <= w_even_next;
            r_sync_status <= w_sync_status_next;
            r_good_cgs    <= w_good_cgs_next;
        end
    end

    assign rx_code_group_out = r_cg_out;
    assign rx_even           = r_even;
    assign code_sync_status  = r_sync_status;

endmodule
